// File: rtl/histogram_scanner.sv
// -----------------------------------------------------------------------------
// histogram_scanner
//
// Purpose
//   Reads every bin (0..DATA_NUM-1) of a histogram engine through its shared
//   read port, streams each (bin index, count) pair out over a valid/ready
//   handshake, and reports the total of all counts and, optionally, the peak.
//
// Optional feature
//   HIS_SCAN_PEAK_EN : when defined, PeakAdd/PeakCount track the largest bin
//                      (ties keep the lower index). When undefined both are 0.
//
// Ports
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   Start              one-cycle scan request, accepted only when idle
//   Valid              engine sample-valid; blocks read issue for 3 cycles
//   HisMemRD/Add       read request and bin address to the engine
//   HisMemRDData       bin count returned two cycles after the request
//   BinValid/BinReady  per-bin output handshake
//   BinAdd/BinCount    bin index and count at the output FIFO head
//   Busy, Done         scan in progress / one-cycle completion pulse
//   Total              sum of all counts of the last scan
//   PeakAdd/PeakCount  index and count of the largest bin
// -----------------------------------------------------------------------------
module histogram_scanner #(
    parameter int DATA_SIZE   = 4,
    parameter int DATA_NUM    = 16,
    parameter int LENGTH_SIZE = 6
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             Start,
    input  logic                             Valid,
    output logic                             HisMemRD,
    output logic [DATA_SIZE-1:0]             HisMemRDAdd,
    input  logic [LENGTH_SIZE-1:0]           HisMemRDData,
    output logic                             BinValid,
    input  logic                             BinReady,
    output logic [DATA_SIZE-1:0]             BinAdd,
    output logic [LENGTH_SIZE-1:0]           BinCount,
    output logic                             Busy,
    output logic                             Done,
    output logic [LENGTH_SIZE+DATA_SIZE-1:0] Total,
    output logic [DATA_SIZE-1:0]             PeakAdd,
    output logic [LENGTH_SIZE-1:0]           PeakCount
);
    localparam int TOTAL_W    = LENGTH_SIZE + DATA_SIZE;
    localparam int FIFO_DEPTH = 3;
    localparam logic [DATA_SIZE-1:0] LAST_ADD = DATA_SIZE'(DATA_NUM - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                 stateReg, stateNext;
    logic [DATA_SIZE-1:0]   addReg;
    logic                   validD1, validD2;
    logic                   rdD1, rdD2;
    logic [DATA_SIZE-1:0]   rdAddD1, rdAddD2;
    logic [DATA_SIZE-1:0]   fifoAdd [FIFO_DEPTH];
    logic [LENGTH_SIZE-1:0] fifoCnt [FIFO_DEPTH];
    logic [1:0]             wrPtr, rdPtr, fifoLevel;
    logic [2:0]             committed;
    logic                   startAcc, portFree, creditOk, issue, push, pop;

    assign startAcc = (stateReg == IDLE) && Start;
    // The engine's read port is shared with sample updates, which occupy it
    // for the Valid cycle and the two after.
    assign portFree = !(Valid || validD1 || validD2);
    // Every issued read already owns a FIFO slot, so a returning count can
    // never find the FIFO full.
    assign committed = {1'b0, fifoLevel} + {2'b00, rdD1} + {2'b00, rdD2};
    assign creditOk  = committed < 3'd3;
    assign push      = rdD2;
    assign pop       = BinValid && BinReady;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stateReg <= IDLE;
        else       stateReg <= stateNext;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:  if (Start) stateNext = SCAN;
            SCAN:  if (issue && (addReg == LAST_ADD)) stateNext = DRAIN;
            DRAIN: if ((fifoLevel == 2'd0) && !rdD1 && !rdD2) stateNext = DONE;
            DONE:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The read strobe is combinational so it can react to Valid in the
    // same cycle.
    always_comb begin
        issue       = (stateReg == SCAN) && portFree && creditOk;
        HisMemRD    = issue;
        HisMemRDAdd = issue ? addReg : '0;
        Busy        = (stateReg != IDLE);
        Done        = (stateReg == DONE);
    end

    // ---------------- Address counter and read pipeline ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addReg  <= '0;
            validD1 <= 1'b0;
            validD2 <= 1'b0;
            rdD1    <= 1'b0;
            rdD2    <= 1'b0;
            rdAddD1 <= '0;
            rdAddD2 <= '0;
        end else begin
            if (startAcc)   addReg <= '0;
            else if (issue) addReg <= addReg + DATA_SIZE'(1);
            validD1 <= Valid;
            validD2 <= validD1;
            rdD1    <= issue;
            rdAddD1 <= addReg;
            rdD2    <= rdD1;
            rdAddD2 <= rdAddD1;
        end
    end

    // ---------------- 3-entry output FIFO ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoAdd[i] <= '0;
                fifoCnt[i] <= '0;
            end
            wrPtr     <= 2'd0;
            rdPtr     <= 2'd0;
            fifoLevel <= 2'd0;
        end else begin
            if (push) begin
                fifoAdd[wrPtr] <= rdAddD2;
                fifoCnt[wrPtr] <= HisMemRDData;
                wrPtr <= (wrPtr == 2'd2) ? 2'd0 : wrPtr + 2'd1;
            end
            if (pop) rdPtr <= (rdPtr == 2'd2) ? 2'd0 : rdPtr + 2'd1;
            case ({push, pop})
                2'b10:   fifoLevel <= fifoLevel + 2'd1;
                2'b01:   fifoLevel <= fifoLevel - 2'd1;
                default: fifoLevel <= fifoLevel;
            endcase
        end
    end

    assign BinValid = (fifoLevel != 2'd0);
    // Stale entries are hidden so the bin outputs read 0 whenever nothing is offered.
    assign BinAdd   = BinValid ? fifoAdd[rdPtr] : '0;
    assign BinCount = BinValid ? fifoCnt[rdPtr] : '0;

    // ---------------- Total ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         Total <= '0;
        else if (startAcc) Total <= '0;
        else if (push)     Total <= Total + TOTAL_W'(HisMemRDData);
    end

    // ---------------- Peak ----------------
`ifdef HIS_SCAN_PEAK_EN
    // Bins arrive in ascending order, so a strict compare keeps the lowest
    // index on ties.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            PeakAdd   <= '0;
            PeakCount <= '0;
        end else if (startAcc) begin
            PeakAdd   <= '0;
            PeakCount <= '0;
        end else if (push && (HisMemRDData > PeakCount)) begin
            PeakAdd   <= rdAddD2;
            PeakCount <= HisMemRDData;
        end
    end
`else
    assign PeakAdd   = '0;
    assign PeakCount = '0;
`endif

endmodule

// File: tb/tb_histogram_scanner.sv
`timescale 1ns/1ps
module tb_histogram_scanner;
    localparam int DS = 4;
    localparam int DN = 16;
    localparam int LS = 6;
    localparam int TW = LS + DS;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          Start = 1'b0;
    logic          Valid = 1'b0;
    logic          BinReady = 1'b0;
    logic          HisMemRD;
    logic [DS-1:0] HisMemRDAdd;
    logic [LS-1:0] HisMemRDData;
    logic          BinValid;
    logic [DS-1:0] BinAdd;
    logic [LS-1:0] BinCount;
    logic          Busy;
    logic          Done;
    logic [TW-1:0] Total;
    logic [DS-1:0] PeakAdd;
    logic [LS-1:0] PeakCount;

    always #5 clk = ~clk;

    histogram_scanner #(.DATA_SIZE(DS), .DATA_NUM(DN), .LENGTH_SIZE(LS)) dut (
        .clk(clk), .rstn(rstn), .Start(Start), .Valid(Valid),
        .HisMemRD(HisMemRD), .HisMemRDAdd(HisMemRDAdd), .HisMemRDData(HisMemRDData),
        .BinValid(BinValid), .BinReady(BinReady), .BinAdd(BinAdd), .BinCount(BinCount),
        .Busy(Busy), .Done(Done), .Total(Total), .PeakAdd(PeakAdd), .PeakCount(PeakCount)
    );

    // Histogram engine model: count returned two cycles after the request,
    // random garbage on the bus otherwise.
    logic [LS-1:0] mem [DN];
    logic          rq1 = 1'b0, rq2 = 1'b0;
    logic [DS-1:0] ra1 = '0, ra2 = '0;
    logic [LS-1:0] junk = '0;
    always @(posedge clk) begin
        rq1  <= HisMemRD;
        ra1  <= HisMemRDAdd;
        rq2  <= rq1;
        ra2  <= ra1;
        junk <= LS'($urandom);
    end
    assign HisMemRDData = rq2 ? mem[ra2] : junk;

    // Scoreboard
    typedef struct packed {
        logic [DS-1:0] a;
        logic [LS-1:0] c;
    } bin_t;
    bin_t   expQ[$];
    bin_t   monE;
    int     compared = 0;
    int     mismatched = 0;
    int     expNextRd = 0;
    int     readsIssued = 0;
    int     transfers = 0;
    int     doneCount = 0;
    logic   vh1 = 1'b0, vh2 = 1'b0;
    longint expTotal = 0;
    int     expPeakAdd = 0;
    int     expPeakCount = 0;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_HisMemRD"},    longint'(HisMemRD), 0);
        check({tag, "_HisMemRDAdd"}, longint'(HisMemRDAdd), 0);
        check({tag, "_BinValid"},    longint'(BinValid), 0);
        check({tag, "_BinAdd"},      longint'(BinAdd), 0);
        check({tag, "_BinCount"},    longint'(BinCount), 0);
        check({tag, "_Busy"},        longint'(Busy), 0);
        check({tag, "_Done"},        longint'(Done), 0);
        check({tag, "_Total"},       longint'(Total), 0);
        check({tag, "_PeakAdd"},     longint'(PeakAdd), 0);
        check({tag, "_PeakCount"},   longint'(PeakCount), 0);
    endtask

    // Reference: every bin in ascending order, sum of all counts, first index of the maximum.
    task automatic prepareExpected();
        int mx;
        expTotal = 0;
        mx = 0;
        for (int k = 0; k < DN; k++) begin
            expQ.push_back({DS'(k), mem[k]});
            expTotal += mem[k];
            if (int'(mem[k]) > mx) mx = int'(mem[k]);
        end
`ifdef HIS_SCAN_PEAK_EN
        expPeakCount = mx;
        expPeakAdd = 0;
        for (int k = DN - 1; k >= 0; k--)
            if (int'(mem[k]) == mx) expPeakAdd = k;
`else
        expPeakCount = 0;
        expPeakAdd = 0;
`endif
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every transfer.
    always @(negedge clk) begin
        if (rstn) begin
            if (Start && !Busy) expNextRd = 0;
            if (HisMemRD) begin
                check("rd_addr", longint'(HisMemRDAdd), expNextRd);
                check("rd_port_free", longint'(Valid || vh1 || vh2), 0);
                expNextRd++;
                readsIssued++;
            end
            if (BinValid && BinReady) begin
                if (expQ.size() == 0) begin
                    check("bin_unexpected", 1, 0);
                end else begin
                    monE = expQ.pop_front();
                    check("bin_add", longint'(BinAdd), longint'(monE.a));
                    check("bin_count", longint'(BinCount), longint'(monE.c));
                end
                transfers++;
            end
            if (Done) begin
                check("done_queue_empty", expQ.size(), 0);
                check("done_total", longint'(Total), expTotal);
                check("done_peak_add", longint'(PeakAdd), expPeakAdd);
                check("done_peak_count", longint'(PeakCount), expPeakCount);
                doneCount++;
            end
            vh2 = vh1;
            vh1 = Valid;
        end else begin
            vh1 = 1'b0;
            vh2 = 1'b0;
        end
    end

    // validMode: 0 none, 1 every 4th cycle, 2 random, 3 only with Start
    // readyMode: 0 always, 1 held low for 20 cycles, 2 random
    task automatic runScan(input int validMode, input int readyMode, input bit restartMid);
        int d0;
        int rd0;
        int cyc;
        d0 = doneCount;
        rd0 = readsIssued;
        cyc = 0;
        prepareExpected();
        while (doneCount == d0 && cyc < 3000) begin
            if (readyMode == 1 && cyc == 20) begin
                check("stall_reads", readsIssued - rd0, 3);
                check("stall_binvalid", longint'(BinValid), 1);
            end
            if (cyc == 1) check("busy_after_start", longint'(Busy), 1);
            Start = (cyc == 0) || (restartMid && cyc == 10);
            case (validMode)
                1:       Valid = (cyc % 4 == 0);
                2:       Valid = ($urandom_range(4) == 0);
                3:       Valid = (cyc == 0);
                default: Valid = 1'b0;
            endcase
            case (readyMode)
                1:       BinReady = (cyc >= 20);
                2:       BinReady = ($urandom_range(9) < 7);
                default: BinReady = 1'b1;
            endcase
            @(posedge clk);
            #1;
            cyc++;
        end
        Start = 1'b0;
        Valid = 1'b0;
        if (doneCount == d0) begin
            check("scan_timeout", 0, 1);
        end else begin
            repeat (4) @(posedge clk);
            #1;
            check("single_done", doneCount - d0, 1);
            check("idle_after_done", longint'(Busy), 0);
            check("total_hold", longint'(Total), expTotal);
            check("peak_hold", longint'(PeakCount), expPeakCount);
        end
    endtask

    task automatic runResetMid();
        int t0;
        int cyc;
        t0 = transfers;
        cyc = 0;
        prepareExpected();
        Start = 1'b1;
        Valid = 1'b0;
        BinReady = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        while (transfers - t0 < 8 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 500) check("reset_wait_timeout", 0, 1);
        #2 rstn = 1'b0;
        #1 checkZero("midreset");
        expQ.delete();
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1 checkZero("after_release");
    endtask

    initial begin
        for (int k = 0; k < DN; k++) mem[k] = LS'(k);
        repeat (3) @(posedge clk);
        #1 checkZero("reset");
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        runScan(0, 0, 1'b0);             // counts k, free-running
        runScan(0, 1, 1'b0);             // output stalled for 20 cycles
        runScan(1, 0, 1'b0);             // Valid every 4th cycle

        for (int k = 0; k < DN; k++) mem[k] = LS'(5);
        mem[3] = LS'(7);
        mem[9] = LS'(7);
        runScan(0, 0, 1'b0);             // tied peak

        for (int k = 0; k < DN; k++) mem[k] = LS'(k);
        runResetMid();
        runScan(0, 0, 1'b0);             // clean scan after abandoned one
        runScan(3, 0, 1'b1);             // Start with Valid, ignored restart

        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < DN; k++) mem[k] = LS'($urandom);
            runScan(2, 2, 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
